wa_pipe: RTL and testbench
==========================

Name: wa_pipe

Overview:
- Parametrised successor to the register-destination select used in the single-cycle datapath.
- Selects the write-back register address (rt / rd / $31 / none) in the decode stage.
- Carries that address and its write-enable through STAGES pipeline registers (E, M, W for STAGES=3).
- Exposes per-stage address/valid plus per-source match flags for the hazard and forwarding units of the pipelined CPU.

Parameters:
- AW, 5: register address width.
- STAGES, 3: number of pipeline stages tracked; index 0 = youngest (E), STAGES-1 = oldest (W). Legal range 1..8.
- NSRC, 2: number of source addresses compared (rs, rt).

Ports:
- clk  in  1  clock, all registers rising-edge.
- reset  in  1  asynchronous, active-high; clears all stage registers.
- rt  in  AW  instruction rt field.
- rd  in  AW  instruction rd field.
- regdst  in  2  0=rt, 1=rd, 2=$31, 3=no destination.
- reg_we  in  1  decode-stage instruction writes a register.
- stall  in  1  decode held; inject bubble into stage 0.
- flush  in  1  kill all younger in-flight stages.
- src_addr  in  NSRC*AW  packed source addresses; slice i = source i.
- stage_wa  out  STAGES*AW  packed write address per stage.
- stage_we  out  STAGES  effective write-enable per stage.
- src_hit  out  NSRC*STAGES  bit i*STAGES+s = source i matches stage s.

Behaviour:
- Decode select (combinational):
  - sel_wa = rt / rd / 31 / 0 for regdst 0/1/2/3; the constant 31 is zero-extended to AW.
  - sel_we = reg_we & (regdst!=3) & (sel_wa!=0). A write to $0 is never tracked as valid.
- Stage 0 update, each rising edge:
  - if flush or stall: wa=0, we=0 (bubble);
  - else: wa=sel_wa, we=sel_we.
- Stages 1..STAGES-2, each rising edge:
  - if flush: wa=0, we=0;
  - else: copy stage s-1.
- Stage STAGES-1 (oldest): always copies stage STAGES-2, so the instruction in write-back still retires. When STAGES=1, flush and stall both bubble stage 0.
- stall does not freeze stages ≥1; they advance normally.
- Simultaneous stall and flush: flush semantics apply; stage 0 receives a bubble in both cases.
- Latency: a decode-stage address appears on stage_wa[0] one edge later and on stage s after s+1 edges.
- Reset: asynchronous assert clears every stage_wa to 0 and every stage_we to 0 immediately. Release is synchronous to the next clk edge. Reset mid-stream discards all in-flight entries.
- src_hit (combinational from registered state and src_addr):
  - hit[i][s] = stage_we[s] & (stage_wa[s]==src_addr[i]) & (src_addr[i]!=0).
  - Multiple stages may hit simultaneously; this block applies no priority in the base configuration.
- No X propagation: unused regdst=3 is fully defined.

Optional Feature:
- Macro: WA_PIPE_PRIORITY_EN.
- With the macro, two extra outputs are added:
  - src_sel, NSRC*3 bits: per source, the index of the youngest hitting stage (lowest s).
  - src_any, NSRC bits: OR of that source's hits.
  - When no stage hits, src_sel=0 and src_any=0.
- Without the macro, neither port exists and priority resolution is left to the forwarding unit.

Decomposition:
- Shared package cpu_pkg:
  - REG_RA=31, REG_ZERO=0, AW_DEFAULT=5.
  - Regdst encoding constants: RD_RT=0, RD_RD=1, RD_RA=2, RD_NONE=3.
  - Typedef reg_addr_t (logic [AW_DEFAULT-1:0]).
- Sub-module wa_stage: one address/we register with bubble and flush inputs, instantiated STAGES times via generate.
- Comparator logic stays in the top-level generate loop.

Test Plan:
- Reset:
  - Assert reset while stages hold rd=8/9/10.
  - Required: all stage_wa=0 and stage_we=0 before the next clk edge; src_hit=0 for src_addr=8.
- Select and pipeline:
  - Issue regdst=1 rd=5, then regdst=0 rt=7, then regdst=2, all with reg_we=1.
  - Required, after 3 edges: stage_wa[2]=5, [1]=7, [0]=31, all we=1.
- $0 and none:
  - Issue rd=0 with regdst=1, then regdst=3 with rt=4, reg_we=1.
  - Required: stage_we[0]=0 in both cases.
  - Required: src_addr=0 never produces a hit.
- Stall:
  - Hold stall=1 for one cycle with rd=12 pending, while stages contain 3/6.
  - Required: stage 0 becomes a bubble and 3/6 shift to stages 1/2; after stall drops, rd=12 enters stage 0.
- Flush:
  - Stages hold 2/4/6; assert flush together with stall.
  - Required: stage 0=0 and stage 1=0 (we=0); stage 2=4 with we=1.
- Hits:
  - Stages hold 9/9/3 with all we=1; src_addr = {9,3}.
  - Required: src0 hits stages 0 and 1; src1 hits stage 2.
  - With WA_PIPE_PRIORITY_EN: src_sel0=0, src_sel1=2, src_any=2'b11.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the pipelined CPU datapath blocks.
//   REG_RA / REG_ZERO : architectural register numbers for $31 and $0.
//   AW_DEFAULT        : default register address width.
//   RD_RT .. RD_NONE  : encoding of the 2-bit regdst destination select.
//   reg_addr_t        : register address at the default width.
package cpu_pkg;

  localparam int AW_DEFAULT = 5;
  localparam int REG_RA     = 31;
  localparam int REG_ZERO   = 0;

  localparam logic [1:0] RD_RT   = 2'd0;
  localparam logic [1:0] RD_RD   = 2'd1;
  localparam logic [1:0] RD_RA   = 2'd2;
  localparam logic [1:0] RD_NONE = 2'd3;

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/wa_stage.sv
// wa_stage: one pipeline slot holding a write-back register address and its
// write-enable.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high, clears the slot
//   bubble : load an empty slot instead of d_wa/d_we
//   flush  : kill the incoming entry (same effect as bubble)
//   d_wa   : next address
//   d_we   : next write-enable
//   q_wa   : registered address
//   q_we   : registered write-enable
module wa_stage #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble,
  input  logic          flush,
  input  logic [AW-1:0] d_wa,
  input  logic          d_we,
  output logic [AW-1:0] q_wa,
  output logic          q_we
);

  // NOTE: state registers use non-blocking assignments so that every stage
  // samples its predecessor's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_wa <= '0;
      q_we <= 1'b0;
    end else if (bubble || flush) begin
      q_wa <= '0;
      q_we <= 1'b0;
    end else begin
      q_wa <= d_wa;
      q_we <= d_we;
    end
  end

endmodule

// File: rtl/wa_pipe.sv
// wa_pipe: decode-stage write-back address select plus a STAGES-deep pipeline
// of (address, write-enable) used by the hazard and forwarding units.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   rt, rd     : instruction register fields
//   regdst     : 0=rt, 1=rd, 2=$31, 3=no destination
//   reg_we     : decode instruction writes a register
//   stall      : decode held, bubble into stage 0
//   flush      : kill stages 0..STAGES-2 (the write-back stage still retires)
//   src_addr   : NSRC packed source addresses, slice i = source i
//   stage_wa   : packed per-stage address, slice s = stage s (0 = youngest)
//   stage_we   : per-stage effective write-enable
//   src_hit    : bit i*STAGES+s set when source i matches stage s
// Optional (macro WA_PIPE_PRIORITY_EN):
//   src_sel    : 3 bits per source, youngest hitting stage index (0 if none)
//   src_any    : per source, any stage hits
module wa_pipe
  import cpu_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int STAGES = 3,
  parameter int NSRC   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          rt,
  input  logic [AW-1:0]          rd,
  input  logic [1:0]             regdst,
  input  logic                   reg_we,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [NSRC*AW-1:0]     src_addr,
  output logic [STAGES*AW-1:0]   stage_wa,
  output logic [STAGES-1:0]      stage_we,
  output logic [NSRC*STAGES-1:0] src_hit
`ifdef WA_PIPE_PRIORITY_EN
  ,
  output logic [NSRC*3-1:0]      src_sel,
  output logic [NSRC-1:0]        src_any
`endif
);

  logic [AW-1:0] sel_wa;
  logic          sel_we;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_wa = '0;
    unique case (regdst)
      RD_RT:   sel_wa = rt;
      RD_RD:   sel_wa = rd;
      RD_RA:   sel_wa = AW'(REG_RA);
      RD_NONE: sel_wa = AW'(REG_ZERO);
      default: sel_wa = '0;
    endcase
  end

  // A write to $0 is discarded by the register file, so it is never tracked.
  assign sel_we = reg_we && (regdst != RD_NONE) && (sel_wa != AW'(REG_ZERO));

  logic [AW-1:0] q_wa [STAGES];
  logic          q_we [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [AW-1:0] d_wa;
    logic          d_we;
    logic          bub;
    logic          kill;

    if (s == 0) begin : g_first
      assign d_wa = sel_wa;
      assign d_we = sel_we;
      assign bub  = stall;
      assign kill = flush;
    end else if (s == STAGES - 1) begin : g_last
      // The write-back stage always advances so its instruction retires.
      assign d_wa = q_wa[s-1];
      assign d_we = q_we[s-1];
      assign bub  = 1'b0;
      assign kill = 1'b0;
    end else begin : g_mid
      assign d_wa = q_wa[s-1];
      assign d_we = q_we[s-1];
      assign bub  = 1'b0;
      assign kill = flush;
    end

    wa_stage #(.AW(AW)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .bubble (bub),
      .flush  (kill),
      .d_wa   (d_wa),
      .d_we   (d_we),
      .q_wa   (q_wa[s]),
      .q_we   (q_we[s])
    );

    assign stage_wa[s*AW +: AW] = q_wa[s];
    assign stage_we[s]          = q_we[s];
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] addr;
    assign addr = src_addr[i*AW +: AW];

    for (genvar s = 0; s < STAGES; s++) begin : g_cmp
      assign src_hit[i*STAGES + s] = q_we[s] && (q_wa[s] == addr) &&
                                     (addr != AW'(REG_ZERO));
    end

`ifdef WA_PIPE_PRIORITY_EN
    // Scan oldest to youngest so the youngest hit overwrites the result.
    always_comb begin
      src_sel[i*3 +: 3] = 3'd0;
      src_any[i]        = 1'b0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        if (src_hit[i*STAGES + s]) begin
          src_sel[i*3 +: 3] = 3'(s);
          src_any[i]        = 1'b1;
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_wa_pipe.sv
// tb_wa_pipe: directed test-plan steps followed by randomized traffic, all
// checked against a reference model that tracks the in-flight instructions
// as a list of (address, valid) entries ordered youngest first.
module tb_wa_pipe;
  import cpu_pkg::*;

  localparam int AW     = 5;
  localparam int STAGES = 3;
  localparam int NSRC   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [AW-1:0]          rt, rd;
  logic [1:0]             regdst;
  logic                   reg_we, stall, flush;
  logic [NSRC*AW-1:0]     src_addr;
  logic [STAGES*AW-1:0]   stage_wa;
  logic [STAGES-1:0]      stage_we;
  logic [NSRC*STAGES-1:0] src_hit;
`ifdef WA_PIPE_PRIORITY_EN
  logic [NSRC*3-1:0]      src_sel;
  logic [NSRC-1:0]        src_any;
`endif

  int tests = 0;
  int fails = 0;

  wa_pipe #(.AW(AW), .STAGES(STAGES), .NSRC(NSRC)) dut (
    .clk      (clk),
    .reset    (reset),
    .rt       (rt),
    .rd       (rd),
    .regdst   (regdst),
    .reg_we   (reg_we),
    .stall    (stall),
    .flush    (flush),
    .src_addr (src_addr),
    .stage_wa (stage_wa),
    .stage_we (stage_we),
    .src_hit  (src_hit)
`ifdef WA_PIPE_PRIORITY_EN
    ,
    .src_sel  (src_sel),
    .src_any  (src_any)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: in-flight instructions, index 0 = youngest.
  typedef struct {
    int wa;
    bit we;
  } entry_t;

  entry_t pipe_q[$];

  task automatic model_reset();
    entry_t e;
    e.wa = 0;
    e.we = 0;
    pipe_q.delete();
    for (int s = 0; s < STAGES; s++) pipe_q.push_back(e);
  endtask

  // One clock edge: the decoded instruction (or a bubble) enters at the
  // front, the oldest retires, and a flush empties every slot except the
  // one that just moved into write-back.
  task automatic model_edge(int f_rt, int f_rd, int f_dst, bit f_we,
                            bit f_stall, bit f_flush);
    entry_t e;
    int dest;
    case (f_dst)
      0: dest = f_rt;
      1: dest = f_rd;
      2: dest = 31;
      default: dest = 0;
    endcase
    e.wa = dest;
    e.we = f_we && (f_dst != 3) && (dest != 0);
    if (f_stall || f_flush) begin
      e.wa = 0;
      e.we = 0;
    end
    pipe_q.push_front(e);
    void'(pipe_q.pop_back());
    if (f_flush) begin
      for (int s = 1; s < STAGES - 1; s++) begin
        pipe_q[s].wa = 0;
        pipe_q[s].we = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [STAGES*AW-1:0]   e_wa;
    logic [STAGES-1:0]      e_we;
    logic [NSRC*STAGES-1:0] e_hit;
    int a;
`ifdef WA_PIPE_PRIORITY_EN
    logic [NSRC*3-1:0]      e_sel;
    logic [NSRC-1:0]        e_any;
    e_sel = '0;
    e_any = '0;
`endif
    e_wa  = '0;
    e_we  = '0;
    e_hit = '0;
    for (int s = 0; s < STAGES; s++) begin
      e_wa[s*AW +: AW] = AW'(pipe_q[s].wa);
      e_we[s]          = pipe_q[s].we;
    end
    for (int i = 0; i < NSRC; i++) begin
      a = int'(src_addr[i*AW +: AW]);
      for (int s = 0; s < STAGES; s++) begin
        e_hit[i*STAGES + s] = pipe_q[s].we && (pipe_q[s].wa == a) && (a != 0);
      end
`ifdef WA_PIPE_PRIORITY_EN
      for (int s = 0; s < STAGES; s++) begin
        if (e_hit[i*STAGES + s] && !e_any[i]) begin
          e_sel[i*3 +: 3] = 3'(s);
          e_any[i]        = 1'b1;
        end
      end
`endif
    end
    check({tag, ".wa"},  32'(stage_wa), 32'(e_wa));
    check({tag, ".we"},  32'(stage_we), 32'(e_we));
    check({tag, ".hit"}, 32'(src_hit),  32'(e_hit));
`ifdef WA_PIPE_PRIORITY_EN
    check({tag, ".sel"}, 32'(src_sel),  32'(e_sel));
    check({tag, ".any"}, 32'(src_any),  32'(e_any));
`endif
  endtask

  // Apply inputs, take one edge in both DUT and model, sample 1 ns later.
  task automatic issue(int i_rt, int i_rd, int i_dst, bit i_we,
                       bit i_stall, bit i_flush);
    rt     = AW'(i_rt);
    rd     = AW'(i_rd);
    regdst = 2'(i_dst);
    reg_we = i_we;
    stall  = i_stall;
    flush  = i_flush;
    @(posedge clk);
    model_edge(i_rt, i_rd, i_dst, i_we, i_stall, i_flush);
    #1;
  endtask

  task automatic set_src(int s0, int s1);
    src_addr = {AW'(s1), AW'(s0)};
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    rt       = '0;
    rd       = '0;
    regdst   = RD_NONE;
    reg_we   = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    src_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("init_reset");
    @(negedge clk);
    reset = 1'b0;

    // Reset while stages hold 8/9/10.
    issue(0, 10, 1, 1, 0, 0);
    issue(0, 9,  1, 1, 0, 0);
    issue(0, 8,  1, 1, 0, 0);
    set_src(8, 9);
    check_all("pre_reset");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset.wa", 32'(stage_wa), 32'd0);
    check("async_reset.we", 32'(stage_we), 32'd0);
    check("async_reset.hit", 32'(src_hit), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Select and pipeline: rd=5, rt=7, $31.
    issue(0, 5, 1, 1, 0, 0);
    issue(7, 0, 0, 1, 0, 0);
    issue(0, 0, 2, 1, 0, 0);
    check("sel.wa2", 32'(stage_wa[2*AW +: AW]), 32'd5);
    check("sel.wa1", 32'(stage_wa[1*AW +: AW]), 32'd7);
    check("sel.wa0", 32'(stage_wa[0 +: AW]), 32'd31);
    check("sel.we", 32'(stage_we), 32'b111);
    check_all("sel");

    // $0 destination and no destination.
    issue(0, 0, 1, 1, 0, 0);
    check("rd0.we0", 32'(stage_we[0]), 32'd0);
    issue(4, 0, 3, 1, 0, 0);
    check("none.we0", 32'(stage_we[0]), 32'd0);
    set_src(0, 0);
    check("zero_src.hit", 32'(src_hit), 32'd0);
    check_all("none");

    // Stall with rd=12 pending while stages hold 3/6.
    issue(0, 6, 1, 1, 0, 0);
    issue(0, 3, 1, 1, 0, 0);
    issue(0, 12, 1, 1, 1, 0);
    check("stall.wa", 32'(stage_wa), 32'({AW'(6), AW'(3), AW'(0)}));
    check("stall.we", 32'(stage_we), 32'b110);
    issue(0, 12, 1, 1, 0, 0);
    check("unstall.wa0", 32'(stage_wa[0 +: AW]), 32'd12);
    check_all("stall");

    // Flush together with stall while stages hold 2/4/6.
    issue(0, 6, 1, 1, 0, 0);
    issue(0, 4, 1, 1, 0, 0);
    issue(0, 2, 1, 1, 0, 0);
    issue(0, 13, 1, 1, 1, 1);
    check("flush.wa", 32'(stage_wa), 32'({AW'(4), AW'(0), AW'(0)}));
    check("flush.we", 32'(stage_we), 32'b100);
    check_all("flush");

    // Hits: stages hold 9/9/3, sources {9,3}.
    issue(0, 3, 1, 1, 0, 0);
    issue(9, 0, 0, 1, 0, 0);
    issue(0, 9, 1, 1, 0, 0);
    set_src(9, 3);
    check("hits.hit", 32'(src_hit), 32'b100011);
`ifdef WA_PIPE_PRIORITY_EN
    check("hits.sel", 32'(src_sel), 32'({3'd2, 3'd0}));
    check("hits.any", 32'(src_any), 32'b11);
`endif
    check_all("hits");

    // Randomized traffic over a small address range so hits are frequent.
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0));
      set_src($urandom_range(0, 7), $urandom_range(0, 7));
      check_all("rand");
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rand_reset");
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
